// File: rtl/ber_window_counter_pkg.sv
// rtl/ber_window_counter_pkg.sv - default parameters and saturating add for the BER window counter
package ber_window_counter_pkg;

  localparam int DEF_LANES   = 1;
  localparam int DEF_CNT_W   = 13;
  localparam int DEF_WIN_LEN = 4096;

  typedef struct packed {
    logic        ovf;
    logic [31:0] sum;
  } sat_res_t;

  // Operands ride in 32 bits; cnt_max clips the result to the caller's count width.
  function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] cnt_max);
    logic [32:0] raw;
    sat_res_t    res;
    raw = {1'b0, a} + {1'b0, b};
    if (raw > {1'b0, cnt_max}) begin
      res.ovf = 1'b1;
      res.sum = cnt_max;
    end else begin
      res.ovf = 1'b0;
      res.sum = raw[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ber_window_counter_popcount.sv
// rtl/ber_window_counter_popcount.sv - combinational population count of the lane error vector
module ber_popcount #(
  parameter int LANES = 1,
  parameter int POP_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits,
  output logic [POP_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) count = count + POP_W'(bits[i]);
  end

endmodule

// File: rtl/ber_window_counter.sv
// rtl/ber_window_counter.sv - multi-lane saturating BER counter with fixed-length error windows
module ber_window_counter
  import ber_window_counter_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic             signal_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             valid,
  input  logic [LANES-1:0] data_i,
  input  logic [LANES-1:0] data_o,
  output logic [CNT_W-1:0] number_right,
  output logic [CNT_W-1:0] number_wrong,
  output logic [CNT_W-1:0] number_total,
  output logic [CNT_W-1:0] win_errors,
  output logic             win_done,
  output logic             overflow
);

  localparam int                WIN_W    = $clog2(WIN_LEN);
  localparam int                POP_W    = $clog2(LANES + 1);
  localparam logic [31:0]       CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);

  logic [POP_W-1:0] nerr;
  logic [31:0]      nerr32;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_acc;
  logic             accept;
  logic             win_last;
  sat_res_t         s_wrong, s_right, s_total, s_win;
  logic             unused_sat;

  ber_popcount #(.LANES(LANES), .POP_W(POP_W)) u_popcount (
    .bits  (data_i ^ data_o),
    .count (nerr)
  );

  assign accept   = en & valid & ~clear;
  assign win_last = (win_cnt == WIN_LAST);
  assign nerr32   = 32'(nerr);

  assign s_wrong = sat_add(32'(number_wrong), nerr32, CNT_MAX);
  assign s_right = sat_add(32'(number_right), 32'(LANES) - nerr32, CNT_MAX);
  assign s_total = sat_add(32'(number_total), 32'(LANES), CNT_MAX);
  assign s_win   = sat_add(32'(win_acc), nerr32, CNT_MAX);

  // Sums never exceed CNT_MAX, so the bits above CNT_W are always zero.
  assign unused_sat = ^{s_wrong.sum, s_right.sum, s_total.sum, s_win.sum};

  always_ff @(posedge signal_clk) begin
    if (!rst_n || clear) begin
      number_right <= '0;
      number_wrong <= '0;
      number_total <= '0;
      win_errors   <= '0;
      win_done     <= 1'b0;
      overflow     <= 1'b0;
      win_cnt      <= '0;
      win_acc      <= '0;
    end else begin
      win_done <= 1'b0;
      if (accept) begin
        number_wrong <= s_wrong.sum[CNT_W-1:0];
        number_right <= s_right.sum[CNT_W-1:0];
        number_total <= s_total.sum[CNT_W-1:0];
        overflow     <= overflow | s_wrong.ovf | s_right.ovf | s_total.ovf | s_win.ovf;
        if (win_last) begin
          win_errors <= s_win.sum[CNT_W-1:0];
          win_done   <= 1'b1;
          win_cnt    <= '0;
          win_acc    <= '0;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          win_acc <= s_win.sum[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ber_window_counter.sv
// tb/tb_ber_window_counter.sv - directed self-checking bench for ber_window_counter
module tb_ber_window_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, clear, valid;
  logic [0:0] d1i, d1o;
  logic [3:0] d4i, d4o;

  logic [12:0] a_right, a_wrong, a_total, a_win_errors;
  logic        a_win_done, a_overflow;
  logic [12:0] b_right, b_wrong, b_total, b_win_errors;
  logic        b_win_done, b_overflow;
  logic [3:0]  c_right, c_wrong, c_total, c_win_errors;
  logic        c_win_done, c_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ber_window_counter #(.LANES(1), .CNT_W(13), .WIN_LEN(8)) dut_a (
    .signal_clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .valid(valid),
    .data_i(d1i), .data_o(d1o),
    .number_right(a_right), .number_wrong(a_wrong), .number_total(a_total),
    .win_errors(a_win_errors), .win_done(a_win_done), .overflow(a_overflow)
  );

  ber_window_counter #(.LANES(4), .CNT_W(13), .WIN_LEN(8)) dut_b (
    .signal_clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .valid(valid),
    .data_i(d4i), .data_o(d4o),
    .number_right(b_right), .number_wrong(b_wrong), .number_total(b_total),
    .win_errors(b_win_errors), .win_done(b_win_done), .overflow(b_overflow)
  );

  ber_window_counter #(.LANES(1), .CNT_W(4), .WIN_LEN(2)) dut_c (
    .signal_clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .valid(valid),
    .data_i(d1i), .data_o(d1o),
    .number_right(c_right), .number_wrong(c_wrong), .number_total(c_total),
    .win_errors(c_win_errors), .win_done(c_win_done), .overflow(c_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc1(input logic ref_bit, input logic rx_bit);
    en = 1'b1; valid = 1'b1; clear = 1'b0;
    d1i = ref_bit; d1o = rx_bit; d4i = 4'h0; d4o = 4'h0;
    step();
  endtask

  task automatic acc4(input logic [3:0] ref_bits, input logic [3:0] rx_bits);
    en = 1'b1; valid = 1'b1; clear = 1'b0;
    d1i = 1'b0; d1o = 1'b0; d4i = ref_bits; d4o = rx_bits;
    step();
  endtask

  task automatic do_clear();
    en = 1'b1; valid = 1'b1; clear = 1'b1;
    d1i = 1'b1; d1o = 1'b0; d4i = 4'hf; d4o = 4'h0;
    step();
    clear = 1'b0; valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; valid = 1'b1; clear = 1'b0;
    d1i = 1'b1; d1o = 1'b0; d4i = 4'hf; d4o = 4'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({a_right, a_wrong, a_total, a_win_errors, a_win_done, a_overflow} !== 54'd0) begin
        failures++;
        $display("FAIL reset_a cycle=%0d got r=%0d w=%0d t=%0d we=%0d wd=%0b ov=%0b exp all 0",
                 i, a_right, a_wrong, a_total, a_win_errors, a_win_done, a_overflow);
      end
      checks++;
      if ({b_total, b_win_done, c_total, c_win_done, c_overflow} !== 20'd0) begin
        failures++;
        $display("FAIL reset_bc cycle=%0d got b_t=%0d b_wd=%0b c_t=%0d c_wd=%0b c_ov=%0b exp all 0",
                 i, b_total, b_win_done, c_total, c_win_done, c_overflow);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) acc1(1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (a_total !== 13'd0 || a_wrong !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid got t=%0d w=%0d exp 0 0", a_total, a_wrong);
    end
    for (int k = 1; k <= 8; k++) begin
      acc1(1'b1, (k == 1) ? 1'b0 : 1'b1);
      if (k < 8) begin
        checks++;
        if (a_win_done !== 1'b0) begin
          failures++;
          $display("FAIL reset_restart_early k=%0d got win_done=%0b exp 0", k, a_win_done);
        end
      end else begin
        checks++;
        if (a_win_done !== 1'b1 || a_win_errors !== 13'd1) begin
          failures++;
          $display("FAIL reset_restart_done got wd=%0b we=%0d exp 1 1", a_win_done, a_win_errors);
        end
      end
    end
  endtask

  task automatic test_window();
    do_clear();
    for (int k = 1; k <= 8; k++) begin
      acc1(1'b1, (k == 2 || k == 5 || k == 7) ? 1'b0 : 1'b1);
      if (k < 8) begin
        checks++;
        if (a_win_done !== 1'b0) begin
          failures++;
          $display("FAIL window_early k=%0d got win_done=%0b exp 0", k, a_win_done);
        end
      end
    end
    checks++;
    if (a_right !== 13'd5 || a_wrong !== 13'd3 || a_total !== 13'd8) begin
      failures++;
      $display("FAIL window_counts got r=%0d w=%0d t=%0d exp 5 3 8", a_right, a_wrong, a_total);
    end
    checks++;
    if (a_win_done !== 1'b1 || a_win_errors !== 13'd3) begin
      failures++;
      $display("FAIL window_done got wd=%0b we=%0d exp 1 3", a_win_done, a_win_errors);
    end
    valid = 1'b0;
    step();
    checks++;
    if (a_win_done !== 1'b0 || a_win_errors !== 13'd3 || a_total !== 13'd8) begin
      failures++;
      $display("FAIL window_hold got wd=%0b we=%0d t=%0d exp 0 3 8", a_win_done, a_win_errors, a_total);
    end
  endtask

  task automatic test_lanes();
    do_clear();
    for (int k = 0; k < 5; k++) acc4(4'b1010, 4'b0110);
    checks++;
    if (b_wrong !== 13'd10 || b_right !== 13'd10 || b_total !== 13'd20) begin
      failures++;
      $display("FAIL lanes_counts got r=%0d w=%0d t=%0d exp 10 10 20", b_right, b_wrong, b_total);
    end
    for (int k = 0; k < 3; k++) acc4(4'b1010, 4'b0101);
    checks++;
    if (b_wrong !== 13'd22 || b_right !== 13'd10 || b_total !== 13'd32) begin
      failures++;
      $display("FAIL lanes_counts2 got r=%0d w=%0d t=%0d exp 10 22 32", b_right, b_wrong, b_total);
    end
    checks++;
    if (b_win_done !== 1'b1 || b_win_errors !== 13'd22 || b_overflow !== 1'b0) begin
      failures++;
      $display("FAIL lanes_window got wd=%0b we=%0d ov=%0b exp 1 22 0", b_win_done, b_win_errors, b_overflow);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    for (int k = 1; k <= 20; k++) begin
      acc1(1'b1, 1'b0);
      checks++;
      if (c_win_done !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL sat_back_to_back k=%0d got win_done=%0b exp %0b", k, c_win_done, (k % 2) == 0);
      end
      if (k == 15) begin
        checks++;
        if (c_wrong !== 4'd15 || c_overflow !== 1'b0) begin
          failures++;
          $display("FAIL sat_edge got w=%0d ov=%0b exp 15 0", c_wrong, c_overflow);
        end
      end
      if (k == 16) begin
        checks++;
        if (c_wrong !== 4'd15 || c_overflow !== 1'b1) begin
          failures++;
          $display("FAIL sat_set got w=%0d ov=%0b exp 15 1", c_wrong, c_overflow);
        end
      end
    end
    checks++;
    if (c_wrong !== 4'd15 || c_total !== 4'd15 || c_right !== 4'd0 || c_win_errors !== 4'd2) begin
      failures++;
      $display("FAIL sat_final got w=%0d t=%0d r=%0d we=%0d exp 15 15 0 2", c_wrong, c_total, c_right, c_win_errors);
    end
    valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (c_overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_sticky got ov=%0b exp 1", c_overflow);
    end
    do_clear();
    checks++;
    if ({c_right, c_wrong, c_total, c_win_errors, c_win_done, c_overflow} !== 18'd0) begin
      failures++;
      $display("FAIL sat_clear got r=%0d w=%0d t=%0d we=%0d wd=%0b ov=%0b exp all 0",
               c_right, c_wrong, c_total, c_win_errors, c_win_done, c_overflow);
    end
  endtask

  task automatic test_clear_window();
    do_clear();
    for (int k = 1; k <= 8; k++) acc1(1'b1, (k <= 2) ? 1'b0 : 1'b1);
    checks++;
    if (a_win_errors !== 13'd2) begin
      failures++;
      $display("FAIL clrwin_setup got we=%0d exp 2", a_win_errors);
    end
    for (int k = 1; k <= 7; k++) acc1(1'b1, (k == 1) ? 1'b0 : 1'b1);
    do_clear();
    checks++;
    if (a_win_done !== 1'b0 || a_wrong !== 13'd0 || a_total !== 13'd0 || a_win_errors !== 13'd0) begin
      failures++;
      $display("FAIL clrwin_discard got wd=%0b w=%0d t=%0d we=%0d exp 0 0 0 0",
               a_win_done, a_wrong, a_total, a_win_errors);
    end
    for (int k = 1; k <= 8; k++) begin
      acc1(1'b1, (k == 8) ? 1'b0 : 1'b1);
      if (k < 8) begin
        checks++;
        if (a_win_done !== 1'b0) begin
          failures++;
          $display("FAIL clrwin_early k=%0d got win_done=%0b exp 0", k, a_win_done);
        end
      end
    end
    checks++;
    if (a_win_done !== 1'b1 || a_win_errors !== 13'd1 || a_total !== 13'd8) begin
      failures++;
      $display("FAIL clrwin_fresh got wd=%0b we=%0d t=%0d exp 1 1 8", a_win_done, a_win_errors, a_total);
    end
  endtask

  task automatic test_enable_hold();
    do_clear();
    for (int k = 1; k <= 4; k++) acc1(1'b1, (k == 1) ? 1'b0 : 1'b1);
    en = 1'b0;
    d1i = 1'b1; d1o = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid = i[0];
      step();
      checks++;
      if (a_total !== 13'd4 || a_wrong !== 13'd1 || a_win_done !== 1'b0) begin
        failures++;
        $display("FAIL hold_frozen i=%0d got t=%0d w=%0d wd=%0b exp 4 1 0", i, a_total, a_wrong, a_win_done);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      acc1(1'b1, (k == 4) ? 1'b0 : 1'b1);
      if (k < 4) begin
        checks++;
        if (a_win_done !== 1'b0) begin
          failures++;
          $display("FAIL hold_early k=%0d got win_done=%0b exp 0", k, a_win_done);
        end
      end
    end
    checks++;
    if (a_win_done !== 1'b1 || a_win_errors !== 13'd2 || a_total !== 13'd8) begin
      failures++;
      $display("FAIL hold_resume got wd=%0b we=%0d t=%0d exp 1 2 8", a_win_done, a_win_errors, a_total);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; valid = 1'b0;
    d1i = 1'b0; d1o = 1'b0; d4i = 4'h0; d4o = 4'h0;
    test_reset();
    test_window();
    test_lanes();
    test_saturate();
    test_clear_window();
    test_enable_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
